joy_shift_reader: RTL
=====================

JOY_SHIFT_READER -- requirements
Module: joy_shift_reader

Interface
REQ-001 SHALL have parameter CLKDIV, default 50: clk cycles per tick (half joy_clk period); legal range 3..65535.
REQ-002 SHALL have parameter GAP, default 64: idle ticks between scans; legal range 0..65535.
REQ-003 SHALL have port clk  in  1  system clock; the only clock.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port joy_data  in  1  serial data from the external 16-bit parallel-in shift chain, asynchronous, active-low buttons.
REQ-006 SHALL have port joy_clk  out  1  shift clock to the chain; the rising edge advances the chain.
REQ-007 SHALL have port joy_load_n  out  1  parallel-load strobe to the chain, active-low.
REQ-008 SHALL have port joy1  out  8  debounced joystick 1, active-high; bit 7 = first bit sampled.
REQ-009 SHALL have port joy2  out  8  debounced joystick 2, active-high; bit 7 = ninth bit sampled.
REQ-010 SHALL have port scan_valid  out  1  one-cycle pulse at the end of every completed scan.
REQ-011 SHALL have port changed  out  1  one-cycle pulse, coincident with scan_valid, when joy1 or joy2 changes value.

Function
REQ-012 SHALL pass joy_data through a 2-flop synchroniser before any use.
REQ-013 SHALL run a free-running prescaler 0..CLKDIV-1 and assert an internal tick on the cycle the count equals CLKDIV-1; every FSM transition SHALL occur only on a tick cycle.
REQ-014 SHALL implement states LOAD, SHIFT_LO, SHIFT_HI and WAIT.
- LOAD: joy_load_n=0, joy_clk=0. On tick: go to SHIFT_LO with bit index 0.
- SHIFT_LO: joy_load_n=1, joy_clk=0. On tick: shift the synchronised joy_data into raw[15:0] MSB-first, then go to SHIFT_HI.
- SHIFT_HI: joy_load_n=1, joy_clk=1. On tick: if index=15, complete the scan (REQ-016) and go to WAIT, or to LOAD if GAP=0; otherwise increment the index and go to SHIFT_LO.
- WAIT: joy_load_n=1, joy_clk=0. Count GAP ticks, then go to LOAD.
REQ-015 SHALL drive joy_clk and joy_load_n directly from registers, with no combinational glitches.
REQ-016 On scan completion SHALL pulse scan_valid for exactly the next cycle and compare the new raw word with the word from the previous completed scan (cand).
- Equal: joy1 <= ~raw[15:8], joy2 <= ~raw[7:0]; changed pulses only if the new value differs from the current outputs.
- Unequal: outputs hold and changed stays 0.
- cand <= raw in both cases.
REQ-017 Scan period SHALL be (33+GAP)*CLKDIV clk cycles. Outputs SHALL reflect a new stable input no later than 2 scan periods plus 3 cycles after the input settles.
REQ-018 The bit index SHALL count 0..15 only; the 16th SHIFT_HI tick SHALL never wrap to a 17th bit.
REQ-019 If rst and tick coincide, rst SHALL win.

Reset
REQ-020 While rst=1, the block SHALL hold: state LOAD, prescaler 0, index 0, joy_load_n=0, joy_clk=0, raw=16'hFFFF, cand=16'hFFFF, joy1=0, joy2=0, scan_valid=0, changed=0, synchroniser flops 1.
REQ-021 Reset asserted mid-scan SHALL abort the scan on the next clk edge with no scan_valid pulse. The first scan after release SHALL start in LOAD, with the first tick CLKDIV cycles after release.

Verification (CLKDIV=4, GAP=2 unless stated)
REQ-022 Release reset with chain model holding 16'hFFFF:
- joy_load_n low for cycles 0..3.
- 16 joy_clk pulses, each 4 cycles low and 4 cycles high.
- scan_valid at cycle 133 and every 140 cycles thereafter.
- joy1=joy2=0 and changed never asserts.
REQ-023 Chain presents 16'h7FFE from reset:
- First scan: scan_valid, joy1=joy2=0, no changed.
- Second scan: joy1=8'h80, joy2=8'h01 and changed=1 in the same cycle as scan_valid.
REQ-024 Chain alternates 16'h0000 / 16'hFFFF on successive scans: joy1 and joy2 stay 0 indefinitely and changed never asserts.
REQ-025 Assert rst for 1 cycle during SHIFT_HI of bit 7:
- No scan_valid for that scan.
- joy_load_n=0 on the next cycle.
- Outputs cleared to 0.
- The next full scan completes normally.
REQ-026 GAP=0: LOAD follows the final SHIFT_HI directly; scan_valid period is 132 cycles.
REQ-027 CLKDIV=3: a data bit changing 1 cycle after joy_clk rises is still captured correctly over 1000 random scans, checked against a 74HC165 reference model.

Source files
------------

// File: rtl/joy_shift_reader.sv
// Scans a 16-bit parallel-in shift chain (two joysticks) with a slow shift clock,
// and publishes the buttons only after two consecutive scans agree.
module joy_shift_reader #(
   parameter int CLKDIV = 50,
   parameter int GAP    = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       joy_data,
   output logic       joy_clk,
   output logic       joy_load_n,
   output logic [7:0] joy1,
   output logic [7:0] joy2,
   output logic       scan_valid,
   output logic       changed
);

   localparam logic [1:0] ST_LOAD     = 2'd0;
   localparam logic [1:0] ST_SHIFT_LO = 2'd1;
   localparam logic [1:0] ST_SHIFT_HI = 2'd2;
   localparam logic [1:0] ST_WAIT     = 2'd3;

   localparam logic [15:0] PRESC_LAST = 16'(CLKDIV - 1);
   localparam logic [15:0] GAP_LAST   = 16'((GAP > 0) ? GAP - 1 : 0);
   localparam bit          HAS_GAP    = (GAP > 0);

   logic [1:0]  sync_q;
   logic        data_s;
   logic [15:0] presc;
   logic        tick;
   logic [1:0]  state;
   logic [3:0]  bit_idx;
   logic [15:0] gap_cnt;
   logic [15:0] raw;
   logic [15:0] cand;
   logic        scan_done;

   assign data_s = sync_q[1];
   assign tick   = (presc == PRESC_LAST);

   // NOTE: every clocked block uses non-blocking assignments so that all flops
   // sample pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (rst) sync_q <= 2'b11;
      else     sync_q <= {sync_q[0], joy_data};
   end

   always_ff @(posedge clk) begin
      if (rst)       presc <= '0;
      else if (tick) presc <= '0;
      else           presc <= presc + 16'd1;
   end

   // joy_clk / joy_load_n are set alongside the state so the pins come straight from flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_LOAD;
         bit_idx    <= '0;
         gap_cnt    <= '0;
         raw        <= 16'hFFFF;
         joy_load_n <= 1'b0;
         joy_clk    <= 1'b0;
         scan_done  <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         if (tick) begin
            case (state)
               ST_LOAD: begin
                  state      <= ST_SHIFT_LO;
                  bit_idx    <= '0;
                  joy_load_n <= 1'b1;
                  joy_clk    <= 1'b0;
               end
               ST_SHIFT_LO: begin
                  raw     <= {raw[14:0], data_s};
                  state   <= ST_SHIFT_HI;
                  joy_clk <= 1'b1;
               end
               ST_SHIFT_HI: begin
                  joy_clk <= 1'b0;
                  if (bit_idx == 4'd15) begin
                     scan_done <= 1'b1;
                     gap_cnt   <= '0;
                     if (HAS_GAP) begin
                        state <= ST_WAIT;
                     end else begin
                        state      <= ST_LOAD;
                        joy_load_n <= 1'b0;
                     end
                  end else begin
                     bit_idx <= bit_idx + 4'd1;
                     state   <= ST_SHIFT_LO;
                  end
               end
               default: begin
                  if (gap_cnt == GAP_LAST) begin
                     state      <= ST_LOAD;
                     joy_load_n <= 1'b0;
                  end else begin
                     gap_cnt <= gap_cnt + 16'd1;
                  end
               end
            endcase
         end
      end
   end

   // Debounce: a word is published only when it matches the previous scan.
   always_ff @(posedge clk) begin
      if (rst) begin
         cand       <= 16'hFFFF;
         joy1       <= '0;
         joy2       <= '0;
         scan_valid <= 1'b0;
         changed    <= 1'b0;
      end else begin
         scan_valid <= scan_done;
         changed    <= 1'b0;
         if (scan_done) begin
            cand <= raw;
            if (raw == cand) begin
               joy1    <= ~raw[15:8];
               joy2    <= ~raw[7:0];
               changed <= (~raw != {joy1, joy2});
            end
         end
      end
   end

endmodule
